// File: rtl/sens_temp_revert_if.sv
// Handshake bundle for the LCM-code to sensor-format reverse converter.
// The master drives the code and start pulse. The slave returns the result and status.
interface sens_temp_revert_if;
  logic [11:0] code_din;
  logic        data_startp;
  logic [15:0] temp_dout;
  logic        calc_busy;
  logic        calc_done;

  modport master (
    output code_din, data_startp,
    input  temp_dout, calc_busy, calc_done
  );

  modport slave (
    input  code_din, data_startp,
    output temp_dout, calc_busy, calc_done
  );
endinterface

// File: rtl/sens_temp_revert.sv
// Converts a 12-bit LCM temperature code back into the smallest 16-bit sensor
// value that maps onto it: ceil(code*SPAN/FULL) - OFFSET, using a bit-serial divider.
module sens_temp_revert (
  input  logic               clk,
  input  logic               rst,
  sens_temp_revert_if.slave  bus
);

  localparam logic [15:0] SPAN     = 16'd46080;
  localparam logic [15:0] OFFSET   = 16'd14080;
  localparam logic [11:0] FULL     = 12'd4095;
  localparam logic [4:0]  LAST_BIT = 5'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state, state_nxt;

  logic [11:0] code_q;
  logic [27:0] num_q;
  // The quotient never exceeds 46080, so its upper 12 bits are always zero.
  // Only the low 16 bits are kept, and the higher bits shift out.
  logic [15:0] quo_q;
  // A restored remainder is always below FULL, so 12 bits are enough to hold it.
  logic [11:0] rem_q;
  logic [4:0]  cnt_q;
  logic [15:0] temp_q;
  logic        done_q;

  logic        accept;
  logic        busy;
  logic [12:0] rem_sh;
  logic [11:0] rem_sub;
  logic        q_bit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every flop
      // samples pre-edge values regardless of process ordering.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.data_startp) state_nxt = MULT;
      MULT: state_nxt = DIV;
      DIV:  if (cnt_q == LAST_BIT) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept = 1'b0;
    busy   = 1'b0;
    unique case (state)
      IDLE:    accept = bus.data_startp;
      MULT:    busy   = 1'b1;
      DIV:     busy   = 1'b1;
      OUT:     busy   = 1'b0;
      default: busy   = 1'b0;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
  always_comb begin
    rem_sh  = {rem_q, num_q[27]};
    q_bit   = (rem_sh >= {1'b0, FULL});
    rem_sub = rem_sh[11:0] - FULL;
  end

  // Datapath. A reset clears every register, so an interrupted conversion is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      num_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      temp_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == OUT);
      if (accept) begin
        code_q <= bus.code_din;
      end
      unique case (state)
        MULT: begin
          // Adding FULL-1 before the floor division turns it into a ceiling.
          num_q <= {16'd0, code_q} * {12'd0, SPAN} + {16'd0, FULL - 12'd1};
          quo_q <= '0;
          rem_q <= '0;
          cnt_q <= '0;
        end
        DIV: begin
          num_q <= {num_q[26:0], 1'b0};
          quo_q <= {quo_q[14:0], q_bit};
          rem_q <= q_bit ? rem_sub : rem_sh[11:0];
          cnt_q <= cnt_q + 5'd1;
        end
        OUT: begin
          temp_q <= quo_q - OFFSET;
        end
        default: ;
      endcase
    end
  end

  assign bus.temp_dout = temp_q;
  assign bus.calc_busy = busy;
  assign bus.calc_done = done_q;

endmodule

// File: tb/tb_sens_temp_revert.sv
// Directed checks for sens_temp_revert: reset state, latency, boundary codes,
// the ceiling property, ignored starts while busy, mid-run reset, and back-to-back starts.
module tb_sens_temp_revert;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  sens_temp_revert_if bus ();

  sens_temp_revert dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.calc_done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference model: the ceiling of code*46080/4095, shifted down by the -55 degC offset.
  function automatic logic [15:0] ref_temp(input int code);
    longint q;
    q = (longint'(code) * 46080 + 4094) / 4095;
    return 16'(q - 14080);
  endfunction

  // Forward conversion from a sensor value back to an LCM code.
  function automatic int fwd(input int s);
    return ((s + 14080) * 4095) / 46080;
  endfunction

  // Called at a negedge just after the start edge. Waits for calc_done and can
  // fire one extra start pulse at cycle poke_k.
  task automatic wait_done(input int poke_k, input logic [11:0] poke_code,
                           output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      bus.data_startp = (k == poke_k);
      if (k == poke_k) bus.code_din = poke_code;
      if (bus.calc_done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.calc_busy === 1'b1) busy_n++;
    end
    bus.data_startp = 1'b0;
  endtask

  task automatic start_pulse(input logic [11:0] c);
    bus.code_din    = c;
    bus.data_startp = 1'b1;
    @(negedge clk);
    bus.data_startp = 1'b0;
    bus.code_din    = 12'hA5A;
  endtask

  task automatic convert(input logic [11:0] c, output logic [15:0] res, output int lat,
                         output int busy_n);
    start_pulse(c);
    wait_done(-1, 12'd0, lat, busy_n);
    res = bus.temp_dout;
  endtask

  initial begin
    logic [15:0] res, res_a;
    int lat, busy_n, base, s;
    logic [11:0] codes [8] = '{12'd2, 12'd3, 12'd12, 12'd1000, 12'd1234,
                               12'd3071, 12'd4094, 12'd45};

    bus.code_din    = 12'd0;
    bus.data_startp = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(bus.temp_dout), 32'h0);
    check("reset_busy", 32'(bus.calc_busy), 32'h0);
    check("reset_done", 32'(bus.calc_done), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Code 0 gives -55 degC. Check the latency, the busy length and the done pulse width.
    convert(12'd0, res, lat, busy_n);
    check("c0_dout", 32'(res), 32'h0000C900);
    check("c0_latency", 32'(lat), 32'd30);
    check("c0_busy_cycles", 32'(busy_n), 32'd29);
    check("c0_busy_at_done", 32'(bus.calc_busy), 32'h0);
    @(negedge clk);
    check("c0_done_width", 32'(bus.calc_done), 32'h0);
    check("c0_dout_hold", 32'(bus.temp_dout), 32'h0000C900);

    convert(12'd4095, res, lat, busy_n);
    check("c4095_dout", 32'(res), 32'h00007D00);
    @(negedge clk);
    convert(12'd1, res, lat, busy_n);
    check("c1_dout", 32'(res), 32'h0000C90C);
    @(negedge clk);
    convert(12'd2048, res, lat, busy_n);
    check("c2048_dout", 32'(res), 32'h00002306);
    check("c2048_latency", 32'(lat), 32'd30);

    // Spot codes: compare against the model, then check the smallest-preimage property.
    foreach (codes[i]) begin
      @(negedge clk);
      convert(codes[i], res, lat, busy_n);
      check($sformatf("code%0d_dout", codes[i]), 32'(res), 32'(ref_temp(int'(codes[i]))));
      s = int'($signed(res));
      check($sformatf("code%0d_fwd", codes[i]), 32'(fwd(s)), 32'(codes[i]));
      check($sformatf("code%0d_fwd_m1", codes[i]), 32'(fwd(s - 1)), 32'(codes[i]) - 32'd1);
    end

    // A start pulse arriving while busy must be ignored.
    @(negedge clk);
    base = done_cnt;
    start_pulse(12'd500);
    wait_done(10, 12'd3500, lat, busy_n);
    res = bus.temp_dout;
    check("ignore_dout", 32'(res), 32'(ref_temp(500)));
    check("ignore_latency", 32'(lat), 32'd30);
    repeat (40) @(negedge clk);
    check("ignore_done_count", 32'(done_cnt - base), 32'd1);

    // A reset mid-conversion abandons it.
    start_pulse(12'd100);
    repeat (15) @(negedge clk);
    base = done_cnt;
    rst = 1'b0;
    #1;
    check("rst_mid_dout", 32'(bus.temp_dout), 32'h0);
    check("rst_mid_busy", 32'(bus.calc_busy), 32'h0);
    check("rst_mid_done", 32'(bus.calc_done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - base), 32'd0);
    convert(12'd3000, res, lat, busy_n);
    check("after_rst_dout", 32'(res), 32'(ref_temp(3000)));

    // Back-to-back: the second start comes in the cycle after calc_done.
    @(negedge clk);
    convert(12'd777, res_a, lat, busy_n);
    check("b2b_first", 32'(res_a), 32'(ref_temp(777)));
    @(negedge clk);
    start_pulse(12'd3333);
    check("b2b_hold", 32'(bus.temp_dout), 32'(res_a));
    check("b2b_busy", 32'(bus.calc_busy), 32'h1);
    wait_done(-1, 12'd0, lat, busy_n);
    check("b2b_second", 32'(bus.temp_dout), 32'(ref_temp(3333)));
    check("b2b_latency", 32'(lat), 32'd30);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
